// File: rtl/alu_issue_decoder_pkg.sv
// Shared ALU definitions: operand width, ALU operation codes, opcode/funct
// constants and the skid-buffer state type used by the issue decoder.
package alu_issue_decoder_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int ALUCtrl_WIDTH = 5;

  // ALU operation codes presented to the EX stage
  typedef enum logic [ALUCtrl_WIDTH-1:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_ADDU  = 5'd2,
    ALU_SUBU  = 5'd3,
    ALU_SLL   = 5'd4,
    ALU_SRL   = 5'd5,
    ALU_SRA   = 5'd6,
    ALU_AND   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_XOR   = 5'd9,
    ALU_NOR   = 5'd10,
    ALU_ADDI  = 5'd11,
    ALU_ADDIU = 5'd12,
    ALU_ANDI  = 5'd13,
    ALU_LUI   = 5'd14,
    ALU_ORI   = 5'd15,
    ALU_SLTI  = 5'd16,
    ALU_SLTIU = 5'd17,
    ALU_XORI  = 5'd18
  } alu_ctrl_e;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational instruction decoder: ALU code, destination register,
// write enable and illegal-instruction flag.
module alu_ctrl_decode
  import alu_issue_decoder_pkg::*;
(
  input  logic [31:0]              instr,
  output logic [ALUCtrl_WIDTH-1:0] alu_ctrl,
  output logic [4:0]               dest,
  output logic                     wen,
  output logic                     illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // Map opcode/funct to an ALU code; anything unrecognised is illegal
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    if (opcode == OP_RTYPE) begin
      unique case (funct)
        FN_ADD:  alu_ctrl = ALU_ADD;
        FN_SUB:  alu_ctrl = ALU_SUB;
        FN_ADDU: alu_ctrl = ALU_ADDU;
        FN_SUBU: alu_ctrl = ALU_SUBU;
        FN_SLL:  alu_ctrl = ALU_SLL;
        FN_SRL:  alu_ctrl = ALU_SRL;
        FN_SRA:  alu_ctrl = ALU_SRA;
        FN_AND:  alu_ctrl = ALU_AND;
        FN_OR:   alu_ctrl = ALU_OR;
        FN_XOR:  alu_ctrl = ALU_XOR;
        FN_NOR:  alu_ctrl = ALU_NOR;
        default: illegal  = 1'b1;
      endcase
    end else begin
      unique case (opcode)
        OP_ADDI:  alu_ctrl = ALU_ADDI;
        OP_ADDIU: alu_ctrl = ALU_ADDIU;
        OP_ANDI:  alu_ctrl = ALU_ANDI;
        OP_LUI:   alu_ctrl = ALU_LUI;
        OP_ORI:   alu_ctrl = ALU_ORI;
        OP_SLTI:  alu_ctrl = ALU_SLTI;
        OP_SLTIU: alu_ctrl = ALU_SLTIU;
        OP_XORI:  alu_ctrl = ALU_XORI;
        default:  illegal  = 1'b1;
      endcase
    end
  end

  // R-type writes rd, I-type writes rt; register 0 is never written
  assign dest = (opcode == OP_RTYPE) ? instr[15:11] : instr[20:16];
  assign wen  = !illegal && (dest != 5'd0);

endmodule

// File: rtl/alu_issue_decoder.sv
// ALU issue stage: decodes an instruction, captures its operands and holds
// the result in a two-entry skid buffer in front of the EX stage.
module alu_issue_decoder #(
  parameter int WORD_WIDTH = alu_issue_decoder_pkg::WORD_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [WORD_WIDTH-1:0] in_rs_val,
  input  logic [WORD_WIDTH-1:0] in_rt_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [alu_issue_decoder_pkg::ALUCtrl_WIDTH-1:0] out_alu_ctrl,
  output logic [WORD_WIDTH-1:0] out_a,
  output logic [WORD_WIDTH-1:0] out_b,
  output logic [15:0]           out_imm1,
  output logic [4:0]            out_imm2,
  output logic [4:0]            out_dest,
  output logic                  out_wen,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  illegal_cnt
);

  import alu_issue_decoder_pkg::*;

  // One buffered entry: ctrl, a, b, imm1, imm2, dest, wen, illegal
  localparam int ENTRY_W = ALUCtrl_WIDTH + 2 * WORD_WIDTH + 16 + 5 + 5 + 2;

  logic [ALUCtrl_WIDTH-1:0] dec_alu_ctrl;
  logic [4:0]               dec_dest;
  logic                     dec_wen;
  logic                     dec_illegal;

  alu_ctrl_decode u_decode (
    .instr    (in_instr),
    .alu_ctrl (dec_alu_ctrl),
    .dest     (dec_dest),
    .wen      (dec_wen),
    .illegal  (dec_illegal)
  );

  skid_state_e          state_reg;
  logic [ENTRY_W-1:0]   head_reg;
  logic [ENTRY_W-1:0]   skid_reg;
  logic                 out_valid_reg;
  logic                 in_ready_reg;
  logic [CNT_WIDTH-1:0] illegal_cnt_reg;

  logic               in_fire;
  logic               out_fire;
  logic [ENTRY_W-1:0] new_entry;

  assign in_fire  = in_valid && in_ready_reg;
  assign out_fire = out_valid_reg && out_ready;

  assign new_entry = {dec_alu_ctrl, in_rs_val, in_rt_val, in_instr[15:0],
                      in_instr[10:6], dec_dest, dec_wen, dec_illegal};

  // Skid-buffer FSM with registered handshakes; head_reg is always the
  // oldest entry, so the presented outputs come straight from a register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_EMPTY;
      head_reg        <= '0;
      skid_reg        <= '0;
      out_valid_reg   <= 1'b0;
      in_ready_reg    <= 1'b1;
      illegal_cnt_reg <= '0;
    end else begin
      if (in_fire && dec_illegal && !flush && (illegal_cnt_reg != {CNT_WIDTH{1'b1}})) begin
        illegal_cnt_reg <= illegal_cnt_reg + 1'b1;
      end
      if (flush) begin
        state_reg     <= S_EMPTY;
        out_valid_reg <= 1'b0;
        in_ready_reg  <= 1'b1;
      end else begin
        case (state_reg)
          S_EMPTY: begin
            if (in_fire) begin
              head_reg      <= new_entry;
              state_reg     <= S_ONE;
              out_valid_reg <= 1'b1;
            end
          end
          S_ONE: begin
            if (in_fire && out_fire) begin
              head_reg <= new_entry;
            end else if (in_fire) begin
              skid_reg     <= new_entry;
              state_reg    <= S_TWO;
              in_ready_reg <= 1'b0;
            end else if (out_fire) begin
              state_reg     <= S_EMPTY;
              out_valid_reg <= 1'b0;
            end
          end
          S_TWO: begin
            if (out_fire) begin
              head_reg     <= skid_reg;
              state_reg    <= S_ONE;
              in_ready_reg <= 1'b1;
            end
          end
          default: begin
            state_reg     <= S_EMPTY;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign illegal_cnt = illegal_cnt_reg;
  assign {out_alu_ctrl, out_a, out_b, out_imm1, out_imm2,
          out_dest, out_wen, out_illegal} = head_reg;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Self-checking bench for alu_issue_decoder: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_alu_issue_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_alu_ctrl;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [15:0] out_imm1;
  logic [4:0]  out_imm2;
  logic [4:0]  out_dest;
  logic        out_wen;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  alu_issue_decoder #(.WORD_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_rs_val    (in_rs_val),
    .in_rt_val    (in_rt_val),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_ctrl (out_alu_ctrl),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_imm1     (out_imm1),
    .out_imm2     (out_imm2),
    .out_dest     (out_dest),
    .out_wen      (out_wen),
    .out_illegal  (out_illegal),
    .illegal_cnt  (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm1;
    logic [4:0]  imm2;
    logic [4:0]  dest;
    bit          wen;
    bit          ill;
  } exp_t;

  exp_t q[$];
  int   model_cnt;
  bit   model_zero;
  int   checks;
  int   failures;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode written from the opcode/funct tables
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    int   op;
    int   fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    e.ctrl = -1;
    if (op == 0) begin
      case (fn)
        32: e.ctrl = 0;  34: e.ctrl = 1;  33: e.ctrl = 2;  35: e.ctrl = 3;
        0:  e.ctrl = 4;  2:  e.ctrl = 5;  3:  e.ctrl = 6;  36: e.ctrl = 7;
        37: e.ctrl = 8;  38: e.ctrl = 9;  39: e.ctrl = 10;
        default: e.ctrl = -1;
      endcase
      e.dest = ins[15:11];
    end else begin
      case (op)
        8:  e.ctrl = 11; 9:  e.ctrl = 12; 12: e.ctrl = 13; 15: e.ctrl = 14;
        13: e.ctrl = 15; 10: e.ctrl = 16; 11: e.ctrl = 17; 14: e.ctrl = 18;
        default: e.ctrl = -1;
      endcase
      e.dest = ins[20:16];
    end
    e.ill = (e.ctrl < 0);
    if (e.ill) e.ctrl = 0;
    e.wen  = !e.ill && (e.dest != 0);
    e.a    = rs;
    e.b    = rt;
    e.imm1 = ins[15:0];
    e.imm2 = ins[10:6];
    return e;
  endfunction

  task automatic compare_all();
    check_value("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check_value("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check_value("illegal_cnt", 64'(illegal_cnt), 64'(model_cnt));
    if (q.size() > 0) begin
      check_value("alu_ctrl", 64'(out_alu_ctrl), 64'(q[0].ctrl));
      check_value("out_a", 64'(out_a), 64'(q[0].a));
      check_value("out_b", 64'(out_b), 64'(q[0].b));
      check_value("imm1", 64'(out_imm1), 64'(q[0].imm1));
      check_value("imm2", 64'(out_imm2), 64'(q[0].imm2));
      check_value("wen", 64'(out_wen), 64'(q[0].wen));
      check_value("illegal", 64'(out_illegal), 64'(q[0].ill));
      if (!q[0].ill) check_value("dest", 64'(out_dest), 64'(q[0].dest));
    end else if (model_zero) begin
      check_value("reset_data", {out_a, out_b}, 64'd0);
      check_value("reset_fields", 64'({out_alu_ctrl, out_imm1, out_imm2, out_dest, out_wen, out_illegal}), 64'd0);
    end
  endtask

  // Drive one cycle, advance the model at the edge, then compare
  task automatic do_cycle(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                          input logic [31:0] rt, input logic ordy, input logic fl, input logic r);
    bit   in_fire;
    bit   out_fire;
    exp_t e;
    rst       = r;
    flush     = fl;
    in_valid  = v;
    in_instr  = ins;
    in_rs_val = rs;
    in_rt_val = rt;
    out_ready = ordy;
    in_fire   = v && (q.size() < 2);
    out_fire  = ordy && (q.size() > 0);
    e = ref_decode(ins, rs, rt);
    @(posedge clk);
    if (r) begin
      q.delete();
      model_cnt  = 0;
      model_zero = 1'b1;
    end else begin
      if (in_fire && e.ill && !fl && model_cnt < 65535) model_cnt++;
      if (fl) q.delete();
      else begin
        if (out_fire) void'(q.pop_front());
        if (in_fire) begin
          q.push_back(e);
          model_zero = 1'b0;
        end
      end
    end
    #1;
    compare_all();
  endtask

  logic [5:0] r_functs [11] = '{6'd32, 6'd34, 6'd33, 6'd35, 6'd0, 6'd2, 6'd3, 6'd36, 6'd37, 6'd38, 6'd39};

  initial begin
    logic [31:0] ins;
    int          base;
    checks     = 0;
    failures   = 0;
    model_cnt  = 0;
    model_zero = 1'b1;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    in_rs_val = '0; in_rt_val = '0; out_ready = 1'b0;

    // Reset state
    do_cycle(0, 0, 0, 0, 0, 0, 1);
    do_cycle(0, 0, 0, 0, 0, 0, 1);
    check_value("rst_in_ready", 64'(in_ready), 64'd1);
    check_value("rst_out_valid", 64'(out_valid), 64'd0);

    // Single instructions, one-cycle latency
    do_cycle(1, 32'h00851020, 7, 9, 1, 0, 0);
    check_value("add_ctrl", 64'(out_alu_ctrl), 64'd0);
    check_value("add_a", 64'(out_a), 64'd7);
    check_value("add_b", 64'(out_b), 64'd9);
    check_value("add_dest", 64'(out_dest), 64'd2);
    check_value("add_wen", 64'(out_wen), 64'd1);
    do_cycle(1, 32'h3C011234, 1, 2, 1, 0, 0);
    check_value("lui_ctrl", 64'(out_alu_ctrl), 64'd14);
    check_value("lui_imm1", 64'(out_imm1), 64'h1234);
    check_value("lui_dest", 64'(out_dest), 64'd1);
    do_cycle(1, 32'h00021903, 3, 4, 1, 0, 0);
    check_value("sra_ctrl", 64'(out_alu_ctrl), 64'd6);
    check_value("sra_imm2", 64'(out_imm2), 64'd4);
    check_value("sra_dest", 64'(out_dest), 64'd3);
    base = int'(illegal_cnt);
    do_cycle(1, 32'h8C220000, 5, 6, 1, 0, 0);
    check_value("lw_illegal", 64'(out_illegal), 64'd1);
    check_value("lw_wen", 64'(out_wen), 64'd0);
    check_value("lw_cnt", 64'(illegal_cnt), 64'(base + 1));
    do_cycle(1, 32'h00000000, 0, 0, 1, 0, 0);
    check_value("nop_ctrl", 64'(out_alu_ctrl), 64'd4);
    check_value("nop_wen", 64'(out_wen), 64'd0);
    do_cycle(0, 0, 0, 0, 1, 0, 0);

    // Backpressure: three offered, two accepted, then drain in order
    do_cycle(1, 32'h00851020, 11, 12, 0, 0, 0);
    do_cycle(1, 32'h3C015678, 13, 14, 0, 0, 0);
    do_cycle(1, 32'h00021903, 15, 16, 0, 0, 0);
    check_value("full_in_ready", 64'(in_ready), 64'd0);
    do_cycle(0, 0, 0, 0, 1, 0, 0);
    check_value("drain1_a", 64'(out_a), 64'd13);
    do_cycle(0, 0, 0, 0, 1, 0, 0);
    check_value("drain_empty", 64'(out_valid), 64'd0);

    // Flush while full with an illegal instruction offered
    do_cycle(1, 32'h00851020, 1, 1, 0, 0, 0);
    do_cycle(1, 32'h00851020, 2, 2, 0, 0, 0);
    base = int'(illegal_cnt);
    do_cycle(1, 32'h8C220000, 3, 3, 1, 1, 0);
    check_value("flush_out_valid", 64'(out_valid), 64'd0);
    check_value("flush_in_ready", 64'(in_ready), 64'd1);
    do_cycle(1, 32'h8C220000, 4, 4, 0, 1, 0);
    check_value("flush_cnt", 64'(illegal_cnt), 64'(base));
    check_value("flush_empty", 64'(out_valid), 64'd0);

    // Reset mid-stream
    do_cycle(1, 32'h8C220000, 5, 5, 0, 0, 0);
    do_cycle(1, 32'h3C011234, 6, 6, 0, 0, 0);
    do_cycle(1, 32'h00851020, 7, 7, 1, 1, 1);
    check_value("rst_mid_valid", 64'(out_valid), 64'd0);
    check_value("rst_mid_cnt", 64'(illegal_cnt), 64'd0);
    check_value("rst_mid_a", 64'(out_a), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 3))
        0: ins[31:26] = 6'd0;
        1: begin ins[31:26] = 6'd0; ins[5:0] = r_functs[$urandom_range(0, 10)]; end
        2: ins[31:26] = 6'(8 + $urandom_range(0, 7));
        default: ;
      endcase
      do_cycle(($urandom_range(0, 3) != 0), ins, $urandom, $urandom,
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
